wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
Owns the single register-file write port in the RISC-V core. Arbitrates between the in-order pipeline write-back (ALU/load result already muxed) and a long-latency unit (mul/div) completing out of band. Registers the winning write toward the register file. Includes an anti-starvation state machine so the long-latency unit is guaranteed a slot.

Parameters:
STARVE_LIMIT, 4, consecutive cycles the B requester may wait before being force-granted (legal range 1..15)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
a_valid  input  1  pipeline write-back request (write enable already qualified)
a_rd  input  REG_ADDR_WIDTH  pipeline destination register
a_data  input  DATA_WIDTH  pipeline write-back data
a_ready  output  1  pipeline request accepted this cycle (0 = pipeline must stall and hold a_*)
b_valid  input  1  long-latency unit result request
b_rd  input  REG_ADDR_WIDTH  long-latency destination register
b_data  input  DATA_WIDTH  long-latency result
b_ready  output  1  B request consumed this cycle (written or squashed)
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  REG_ADDR_WIDTH  register-file write address (registered)
rf_wdata  output  DATA_WIDTH  register-file write data (registered)

Behaviour:
- Reset: asynchronous, active-high. While rst is high: rf_we=0, rf_waddr=0, rf_wdata=0, wait_cnt=0, state=NORMAL. a_ready and b_ready are combinational and are not forced by reset.
- Handshake: a transfer occurs when valid && ready. B must hold b_valid/b_rd/b_data stable until b_ready. A must hold a_* while a_ready=0.
- FSM states: NORMAL, FORCE_B.
- NORMAL:
  - a_ready=1.
  - B is granted only when a_valid=0.
  - If a_valid && b_valid && a_rd==b_rd && a_rd!=0: WAW squash. A is written, b_ready=1, and B is dropped because A is the younger result.
  - Otherwise, when B is not granted, b_ready=0.
- wait_cnt:
  - Increments each cycle b_valid && !b_ready.
  - Clears when b_ready=1 or b_valid=0.
  - When b_valid && !b_ready and wait_cnt+1 == STARVE_LIMIT, next state is FORCE_B.
- FORCE_B:
  - If b_valid: a_ready=0, B is granted and written, b_ready=1, wait_cnt cleared, next state NORMAL.
  - If b_valid=0 (protocol violation): a_ready=1 and the cycle behaves as NORMAL; next state NORMAL.
- Output register update:
  - Each cycle, rf_we <= (granted request exists) && (granted rd != 0).
  - When rf_we is next 1, rf_waddr/rf_wdata take the granted rd/data. Otherwise they hold their previous values.
  - A squashed B never reaches the output.
- Latency: a grant in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1. There is exactly one write per cycle at most.
- x0 writes: the request is accepted (ready=1) but rf_we stays 0.
- Reset mid-operation: a pending B stays asserted at the inputs and is re-arbitrated from NORMAL with wait_cnt=0 after rst falls. Any in-flight registered write is lost.
- Widths: wait_cnt is 4 bits. The comparison is unsigned.

Optional Feature:
- Macro: WB_ARB_PERF_CNT_EN.
- With the macro, add output perf_force_cnt (32 bits). It counts FORCE_B grants, resets to 0 and saturates at 0xFFFF_FFFF.
- Also add output perf_a_stall_cnt (32 bits). It counts cycles with a_valid && !a_ready and saturates the same way.
- Without the macro, these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- my_pkg holds DATA_WIDTH, REG_ADDR_WIDTH (5), and the typedef wb_arb_state_e {NORMAL, FORCE_B}.
- No sub-module is needed for the core logic.
- The optional counters may use a small sat_counter sub-module, instantiated twice under the macro.

Test Plan:
- A only: a_valid=1, a_rd=5, a_data=0x1234 → a_ready=1 same cycle. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
- B only: b_valid=1, b_rd=7, b_data=0xDEAD → b_ready=1 same cycle. Next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEAD.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: a_valid held high with rd=3, and b_valid high with rd=9.
  - A is written in cycles 0–3 and b_ready=0 throughout them.
  - Cycle 4: a_ready=0, b_ready=1; next cycle rf_waddr=9.
  - Cycle 5: A is accepted again.
- WAW squash: a_rd=b_rd=12, a_data=0x1, b_data=0x2 in the same cycle → a_ready=1, b_ready=1. Exactly one write follows: rf_waddr=12, rf_wdata=0x1.
- x0: a_valid=1, a_rd=0 → a_ready=1, rf_we stays 0.
- Reset mid-starvation:
  - Assert rst after wait_cnt=3 → rf_we drops immediately.
  - After release with a_valid and b_valid both held, B waits a full 4 cycles again before its forced grant.

Source files
------------

// File: rtl/my_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DATA_WIDTH      : width of the register-file data path
//   REG_ADDR_WIDTH  : width of a register index (x0..x31)
//   wb_arb_state_e  : arbiter FSM state encoding
package my_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } wb_arb_state_e;

endpackage : my_pkg

// File: rtl/wb_port_arbiter_sat_counter.sv
// Saturating event counter.
// Counts cycles where inc is high. It sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count enable for this cycle
//   count : current count value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule : sat_counter

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Arbitrates the single RF write port between the in-order pipeline
// write-back (A) and a long-latency unit (B). A wins by default.
// B is granted when A is idle, or when B has waited STARVE_LIMIT cycles.
// In that forced case, A is stalled for one cycle.
// If A and B target the same non-zero register in the same cycle, the B
// result is dropped. The A result is younger, so B's write must not land.
// The winning write is registered and appears one cycle after the grant.
// Writes to x0 are accepted but do not assert rf_we.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   a_valid/a_rd/a_data       : pipeline write-back request
//   a_ready                   : A accepted this cycle (combinational)
//   b_valid/b_rd/b_data       : long-latency unit request
//   b_ready                   : B consumed (written or squashed) this cycle
//   rf_we/rf_waddr/rf_wdata   : registered register-file write port
//
// Optional feature (macro WB_ARB_PERF_CNT_EN):
//   perf_force_cnt   : saturating count of forced B grants
//   perf_a_stall_cnt : saturating count of cycles with a_valid && !a_ready
module wb_port_arbiter
  import my_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_valid,
  input  logic [REG_ADDR_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0]     a_data,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [REG_ADDR_WIDTH-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0]     b_data,
  output logic                      b_ready,
`ifdef WB_ARB_PERF_CNT_EN
  output logic [31:0]               perf_force_cnt,
  output logic [31:0]               perf_a_stall_cnt,
`endif
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_arb_state_e             state_reg, state_next;
  logic [3:0]                wait_cnt_reg, wait_cnt_next;
  logic                      rf_we_reg, rf_we_next;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_reg, rf_waddr_next;
  logic [DATA_WIDTH-1:0]     rf_wdata_reg, rf_wdata_next;

  logic grant_a;
  logic grant_b;
  logic force_b;
  logic waw_squash;

  // Arbitration, FSM next state and output-register next values.
  always_comb begin
    a_ready       = 1'b1;
    b_ready       = 1'b0;
    grant_a       = 1'b0;
    grant_b       = 1'b0;
    waw_squash    = 1'b0;
    state_next    = NORMAL;
    wait_cnt_next = 4'd0;
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;

    // FORCE_B without a B request is a protocol violation.
    // That cycle is arbitrated like NORMAL.
    force_b = (state_reg == FORCE_B) && b_valid;

    if (force_b) begin
      a_ready = 1'b0;
      grant_b = 1'b1;
      b_ready = 1'b1;
    end else begin
      grant_a    = a_valid;
      grant_b    = !a_valid && b_valid;
      waw_squash = a_valid && b_valid && (a_rd == b_rd) && (a_rd != '0);
      b_ready    = grant_b || waw_squash;
    end

    // Starvation tracking: count cycles B is left waiting.
    if (b_valid && !b_ready) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
      if ((wait_cnt_reg + 4'd1) == LIMIT) begin
        state_next = FORCE_B;
      end
    end

    // Registered write. Address and data hold when no write is issued.
    if (grant_a) begin
      rf_we_next = (a_rd != '0);
      if (a_rd != '0) begin
        rf_waddr_next = a_rd;
        rf_wdata_next = a_data;
      end
    end else if (grant_b) begin
      rf_we_next = (b_rd != '0);
      if (b_rd != '0) begin
        rf_waddr_next = b_rd;
        rf_wdata_next = b_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= NORMAL;
      wait_cnt_reg <= 4'd0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;

`ifdef WB_ARB_PERF_CNT_EN
  sat_counter #(.WIDTH(32)) u_force_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (force_b),
    .count (perf_force_cnt)
  );

  sat_counter #(.WIDTH(32)) u_a_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (a_valid && !a_ready),
    .count (perf_a_stall_cnt)
  );
`endif

endmodule : wb_port_arbiter
